// File: rtl/modmul_pkg.sv
`default_nettype none
// modmul_pkg: state encoding, bus width and reference moduli for the reduction initiator.
// Revision 1.0
package modmul_pkg;

  localparam int DATA_LENGTH = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [DATA_LENGTH-1:0] KYBER_Q     = 64'd3329;
  localparam logic [DATA_LENGTH-1:0] DILITHIUM_Q = 64'd8380417;
  localparam logic [DATA_LENGTH-1:0] FERMAT_F4   = 64'd65537;
  localparam logic [DATA_LENGTH-1:0] MERSENNE_31 = 64'd2147483647;

endpackage
`default_nettype wire

// File: rtl/serial_shiftadd_mul.sv
`default_nettype none
// serial_shiftadd_mul: radix-2 shift-add multiplier, one multiplier bit per step.
// Revision 1.0
module serial_shiftadd_mul
  import modmul_pkg::*;
#(
  parameter int OPERAND_LENGTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          step,
  input  logic [OPERAND_LENGTH-1:0]     a,
  input  logic [OPERAND_LENGTH-1:0]     b,
  output logic [2*OPERAND_LENGTH-1:0]   acc,
  output logic                          done
);

  localparam int CW = $clog2(OPERAND_LENGTH) + 1;

  logic [2*OPERAND_LENGTH-1:0] mcand;
  logic [OPERAND_LENGTH-1:0]   mult;
  logic [CW-1:0]               count;

  // done fires together with the final step so the FSM leaves MUL on schedule
  assign done = step && (count == CW'(OPERAND_LENGTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= (2*OPERAND_LENGTH)'(a);
      mult  <= b;
      count <= '0;
    end else if (step) begin
      if (mult[0]) begin
        acc <= acc + mcand;
      end
      mcand <= mcand << 1;
      mult  <= mult >> 1;
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/modmul_reduce_initiator.sv
`default_nettype none
// modmul_reduce_initiator: multiplies a*b serially, hands the product to a reducer, returns a*b mod m.
// Optional watchdog in WAIT enabled by MODMUL_TIMEOUT_EN (adds parameter TIMEOUT_CYCLES). Revision 1.0
module modmul_reduce_initiator
  import modmul_pkg::*;
#(
  parameter int DATA_LENGTH    = modmul_pkg::DATA_LENGTH,
  parameter int OPERAND_LENGTH = 32
`ifdef MODMUL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [OPERAND_LENGTH-1:0] a_i,
  input  logic [OPERAND_LENGTH-1:0] b_i,
  input  logic [DATA_LENGTH-1:0]    m_i,
  output logic                      red_start_o,
  output logic [DATA_LENGTH-1:0]    red_x_o,
  output logic [DATA_LENGTH-1:0]    red_m_o,
  output logic [DATA_LENGTH-1:0]    red_m_bl_o,
  input  logic [DATA_LENGTH-1:0]    red_result_i,
  input  logic                      red_valid_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_LENGTH-1:0]    result_o,
  output logic                      error_o
);

  state_t state_q, state_d;

  logic [DATA_LENGTH-1:0]      m_q;
  logic [DATA_LENGTH-1:0]      m_bl_q;
  logic [DATA_LENGTH-1:0]      m_bl_d;
  logic [DATA_LENGTH-1:0]      result_q;
  logic                        error_q;
  logic                        mul_load;
  logic                        mul_step;
  logic                        mul_done;
  logic [2*OPERAND_LENGTH-1:0] acc;
  logic                        m_bad;
  logic                        timeout_hit;

  assign m_bad = m_i < DATA_LENGTH'(2);

  serial_shiftadd_mul #(
    .OPERAND_LENGTH(OPERAND_LENGTH)
  ) u_mul (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (mul_load),
    .step (mul_step),
    .a    (a_i),
    .b    (b_i),
    .acc  (acc),
    .done (mul_done)
  );

`ifdef MODMUL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (state_q == WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Priority encoder: position of the highest set bit of the latched modulus, plus one
  always_comb begin
    m_bl_d = '0;
    for (int i = 0; i < DATA_LENGTH; i++) begin
      if (m_q[i]) begin
        m_bl_d = DATA_LENGTH'(i + 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          mul_load = 1'b1;
          state_d  = m_bad ? OUT : MUL;
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_done) begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (red_valid_i || timeout_hit) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_q      <= '0;
      m_bl_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid_i) begin
        m_q <= m_i;
        if (m_bad) begin
          result_q <= '0;
          error_q  <= 1'b1;
        end
      end
      // Bit length is captured on the MUL->ISSUE edge so it is valid alongside red_start_o
      if (state_q == MUL && mul_done) begin
        m_bl_q <= m_bl_d;
      end
      if (state_q == WAIT) begin
        if (red_valid_i) begin
          result_q <= red_result_i;
          error_q  <= 1'b0;
        end else if (timeout_hit) begin
          result_q <= '0;
          error_q  <= 1'b1;
        end
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign red_start_o = (state_q == ISSUE);
  assign out_valid_o = (state_q == OUT);
  assign red_x_o     = DATA_LENGTH'(acc);
  assign red_m_o     = m_q;
  assign red_m_bl_o  = m_bl_q;
  assign result_o    = result_q;
  assign error_o     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_modmul_reduce_initiator.sv
`default_nettype none
// tb_modmul_reduce_initiator: directed vectors against a 5-cycle behavioural reducer.
module tb_modmul_reduce_initiator;
  import modmul_pkg::*;

  localparam int DL       = 64;
  localparam int OL       = 32;
  localparam int RESP_LAT = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [OL-1:0] a_i;
  logic [OL-1:0] b_i;
  logic [DL-1:0] m_i;
  logic          red_start_o;
  logic [DL-1:0] red_x_o;
  logic [DL-1:0] red_m_o;
  logic [DL-1:0] red_m_bl_o;
  logic [DL-1:0] red_result_i;
  logic          red_valid_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DL-1:0] result_o;
  logic          error_o;

  int checks   = 0;
  int failures = 0;
  int start_cycles = 0;

  logic          silent       = 1'b0;
  logic          resp_valid   = 1'b0;
  logic [DL-1:0] resp_result  = '0;
  logic          stray_valid  = 1'b0;
  logic [DL-1:0] stray_result = '0;
  logic [DL-1:0] resp_x, resp_m;
  logic [DL-1:0] seen_x = '0, seen_m = '0, seen_bl = '0;

  assign red_valid_i  = resp_valid | stray_valid;
  assign red_result_i = resp_valid ? resp_result : stray_result;

  always #5 clk_i = ~clk_i;

  modmul_reduce_initiator dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .m_i          (m_i),
    .red_start_o  (red_start_o),
    .red_x_o      (red_x_o),
    .red_m_o      (red_m_o),
    .red_m_bl_o   (red_m_bl_o),
    .red_result_i (red_result_i),
    .red_valid_i  (red_valid_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .result_o     (result_o),
    .error_o      (error_o)
  );

  always @(negedge clk_i) begin
    if (red_start_o) begin
      start_cycles++;
      seen_x  = red_x_o;
      seen_m  = red_m_o;
      seen_bl = red_m_bl_o;
    end
  end

  // Reducer model: result becomes valid RESP_LAT cycles after the start cycle
  always begin
    @(negedge clk_i);
    if (red_start_o && !silent && !rst_i) begin
      resp_x = red_x_o;
      resp_m = red_m_o;
      repeat (RESP_LAT) @(posedge clk_i);
      #1;
      resp_result = resp_x % resp_m;
      resp_valid  = 1'b1;
      @(posedge clk_i);
      #1;
      resp_valid  = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " in_ready"},   in_ready_o,  1);
    check({tag, " out_valid"},  out_valid_o, 0);
    check({tag, " red_start"},  red_start_o, 0);
    check({tag, " red_x"},      red_x_o,     0);
    check({tag, " red_m"},      red_m_o,     0);
    check({tag, " red_m_bl"},   red_m_bl_o,  0);
    check({tag, " result"},     result_o,    0);
    check({tag, " error"},      error_o,     0);
  endtask

  task automatic handshake(input logic [OL-1:0] a, input logic [OL-1:0] b, input logic [DL-1:0] m);
    a_i = a; b_i = b; m_i = m; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [OL-1:0] a, input logic [OL-1:0] b,
                         input logic [DL-1:0] m, input logic [DL-1:0] exp_res, input logic exp_err,
                         input logic [DL-1:0] exp_bl, input int exp_lat, input int exp_starts,
                         input int hold);
    int cyc;
    int starts0;
    starts0 = start_cycles;
    handshake(a, b, m);
    cyc = 1;
    while (!out_valid_o && cyc < 400) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"},  result_o, exp_res);
    check({tag, " error"},   error_o,  exp_err);
    check({tag, " start_cycles"}, start_cycles - starts0, exp_starts);
    if (exp_starts == 1) begin
      check({tag, " red_x"},    seen_x,  DL'(a) * DL'(b));
      check({tag, " red_m"},    seen_m,  m);
      check({tag, " red_m_bl"}, seen_bl, exp_bl);
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk_i);
      #1;
      check({tag, " hold result"},    result_o,    exp_res);
      check({tag, " hold out_valid"}, out_valid_o, 1);
      check({tag, " hold in_ready"},  in_ready_o,  0);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    check({tag, " after accept out_valid"}, out_valid_o, 0);
    check({tag, " after accept in_ready"},  in_ready_o,  1);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0; m_i = '0;
    #12;
    check_idle_reset("reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    run_req("kyber", 32'd3000, 32'd3000, KYBER_Q, 64'd1713, 1'b0, 64'd12, 39, 1, 0);
    run_req("dilithium", 32'd8380416, 32'd8380416, DILITHIUM_Q, 64'd1, 1'b0, 64'd23, 39, 1, 0);
    run_req("fermat", 32'd65536, 32'd65536, FERMAT_F4, 64'd1, 1'b0, 64'd17, 39, 1, 0);
    run_req("mersenne", 32'd2147483646, 32'd2, MERSENNE_31, 64'd2147483645, 1'b0, 64'd31, 39, 1, 10);

    // Reset in the middle of MUL, then a stray reducer pulse while idle
    handshake(32'd3000, 32'd3000, KYBER_Q);
    repeat (9) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_idle_reset("midmul reset");
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    stray_result = 64'd123;
    stray_valid  = 1'b1;
    @(posedge clk_i);
    #1;
    stray_valid  = 1'b0;
    check("stray in_ready",  in_ready_o,  1);
    check("stray out_valid", out_valid_o, 0);
    check("stray result",    result_o,    0);
    run_req("kyber rerun", 32'd3000, 32'd3000, KYBER_Q, 64'd1713, 1'b0, 64'd12, 39, 1, 0);

    run_req("m=1", 32'd5, 32'd7, 64'd1, 64'd0, 1'b1, 64'd0, 1, 0, 0);
    run_req("m=0", 32'd5, 32'd7, 64'd0, 64'd0, 1'b1, 64'd0, 1, 0, 0);

    silent = 1'b1;
`ifdef MODMUL_TIMEOUT_EN
    run_req("timeout", 32'd3000, 32'd3000, KYBER_Q, 64'd0, 1'b1, 64'd12, 98, 1, 0);
`else
    handshake(32'd3000, 32'd3000, KYBER_Q);
    repeat (150) @(posedge clk_i);
    #1;
    check("silent out_valid", out_valid_o, 0);
    check("silent in_ready",  in_ready_o,  0);
    check("silent red_x",     red_x_o,     64'd9000000);
    check("silent red_m_bl",  red_m_bl_o,  64'd12);
    check("silent red_start", red_start_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
`endif
    silent = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
